// File: rtl/data_sram_responder_if.sv
`default_nettype none
// ============================================================================
// data_sram_responder_if : SRAM-style CPU data port (en/we/addr/wdata/rdata)
// Rev 1.0
// ============================================================================
interface data_sram_responder_if;
   logic        en;
   logic [3:0]  we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output en, output we, output addr, output wdata, input rdata);
   modport slave  (input en, input we, input addr, input wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// data_sram_responder : word RAM with byte-lane writes plus LED/switch/timer MMIO
// Rev 1.0
// ============================================================================
module data_sram_responder #(
   parameter int          ADDR_W    = 12,
   parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   data_sram_responder_if.slave   bus,
   input  logic [7:0]             switch,
   output logic [15:0]            led,
   output logic                   timer_irq
);

   localparam logic [13:0] OFF_LED    = 14'h0;
   localparam logic [13:0] OFF_SWITCH = 14'h1;
   localparam logic [13:0] OFF_TIMER  = 14'h2;
   localparam logic [13:0] OFF_CMP    = 14'h3;
   localparam logic [13:0] OFF_STATUS = 14'h4;

   logic [31:0] mem [2**ADDR_W];

   logic [31:0] rdata_q, rdata_d;
   logic [15:0] led_q, led_d;
   logic [7:0]  sw_meta_q, sw_sync_q;
   logic [31:0] timer_q, timer_d;
   logic [31:0] cmp_q, cmp_d;
   logic        status_q, status_d;

   logic              is_mmio;
   logic [13:0]       off;
   logic [ADDR_W-1:0] widx;
   logic              rd, wr, mmio_wr, ram_wr, match;
   logic [31:0]       mmio_rdata;
   logic              unused_addr;

   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      return r;
   endfunction

   assign is_mmio     = (bus.addr[31:16] == MMIO_BASE[31:16]);
   assign off         = bus.addr[15:2];
   assign widx        = bus.addr[ADDR_W+1:2];
   assign rd          = bus.en && (bus.we == 4'h0);
   assign wr          = bus.en && (bus.we != 4'h0);
   assign mmio_wr     = wr && is_mmio;
   assign ram_wr      = wr && !is_mmio;
   assign match       = (timer_q == cmp_q);
   assign unused_addr = ^bus.addr[1:0];

   always_comb begin
      mmio_rdata = 32'h0;
      case (off)
         OFF_LED:    mmio_rdata = {16'h0, led_q};
         OFF_SWITCH: mmio_rdata = {24'h0, sw_sync_q};
         OFF_TIMER:  mmio_rdata = timer_q;
         OFF_CMP:    mmio_rdata = cmp_q;
         OFF_STATUS: mmio_rdata = {31'h0, status_q};
         default:    mmio_rdata = 32'h0;
      endcase
   end

   always_comb begin
      rdata_d  = is_mmio ? mmio_rdata : mem[widx];
      led_d    = led_q;
      cmp_d    = cmp_q;
      timer_d  = timer_q + 32'd1;
      status_d = status_q;
      if (mmio_wr) begin
         case (off)
            OFF_LED: begin
               if (bus.we[0]) led_d[7:0]  = bus.wdata[7:0];
               if (bus.we[1]) led_d[15:8] = bus.wdata[15:8];
            end
            OFF_TIMER:  timer_d = lane_merge(timer_q, bus.wdata, bus.we);
            OFF_CMP:    cmp_d   = lane_merge(cmp_q, bus.wdata, bus.we);
            OFF_STATUS: if (bus.we[0] && bus.wdata[0]) status_d = 1'b0;
            default: ;
         endcase
      end
      // A match on the same edge as a clear must leave the flag set
      if (match) status_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q   <= 32'h0;
         led_q     <= 16'h0;
         sw_meta_q <= 8'h0;
         sw_sync_q <= 8'h0;
         timer_q   <= 32'h0;
         cmp_q     <= 32'hffff_ffff;
         status_q  <= 1'b0;
      end else begin
         if (rd) rdata_q <= rdata_d;
         led_q     <= led_d;
         sw_meta_q <= switch;
         sw_sync_q <= sw_meta_q;
         timer_q   <= timer_d;
         cmp_q     <= cmp_d;
         status_q  <= status_d;
      end
   end

   // RAM contents survive reset; only the write is suppressed while it is held
   always_ff @(posedge clk) begin
      if (!reset && ram_wr) begin
         for (int i = 0; i < 4; i++)
            if (bus.we[i]) mem[widx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
   end

   assign bus.rdata = rdata_q;
   assign led       = led_q;
   assign timer_irq = status_q;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// ============================================================================
// tb_data_sram_responder : directed vector table plus timer/switch/reset sequences
// Rev 1.0
// ============================================================================
module tb_data_sram_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  switch;
   logic [15:0] led;
   logic        timer_irq;

   data_sram_responder_if bus ();

   data_sram_responder #(.ADDR_W(12), .MMIO_BASE(32'hbfaf_0000)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .switch    (switch),
      .led       (led),
      .timer_irq (timer_irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        en;
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [15:0] exp_led;
   } vec_t;

   localparam logic [31:0] MB = 32'hbfaf_0000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic access(input logic e, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] d);
      bus.en    = e;
      bus.we    = w;
      bus.addr  = a;
      bus.wdata = d;
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      bus.we = 4'h0;
   endtask

   task automatic idle();
      access(1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   vec_t vecs[19];

   initial begin
      vecs[0]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,          32'h0000_0000, 16'h0000};
      vecs[1]  = '{1'b1, 4'hf, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 16'h0000};
      vecs[2]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,          32'h1234_5678, 16'h0000};
      vecs[3]  = '{1'b1, 4'h5, 32'h0000_0010, 32'haabb_ccdd, 32'h1234_5678, 16'h0000};
      vecs[4]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,          32'h12bb_56dd, 16'h0000};
      vecs[5]  = '{1'b1, 4'hf, 32'h0000_0020, 32'hdead_beef, 32'h12bb_56dd, 16'h0000};
      vecs[6]  = '{1'b1, 4'h0, 32'h0000_0020, 32'h0,          32'hdead_beef, 16'h0000};
      vecs[7]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,          32'h12bb_56dd, 16'h0000};
      vecs[8]  = '{1'b1, 4'h0, 32'h0000_0022, 32'h0,          32'hdead_beef, 16'h0000};
      vecs[9]  = '{1'b1, 4'hf, 32'h0000_4010, 32'h1111_2222, 32'hdead_beef, 16'h0000};
      vecs[10] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,          32'h1111_2222, 16'h0000};
      vecs[11] = '{1'b1, 4'hf, MB,            32'hffff_a5a5, 32'h1111_2222, 16'ha5a5};
      vecs[12] = '{1'b1, 4'h0, MB,            32'h0,          32'h0000_a5a5, 16'ha5a5};
      vecs[13] = '{1'b1, 4'hc, MB,            32'h1234_0000, 32'h0000_a5a5, 16'ha5a5};
      vecs[14] = '{1'b1, 4'h0, MB,            32'h0,          32'h0000_a5a5, 16'ha5a5};
      vecs[15] = '{1'b1, 4'h0, MB + 32'h40,   32'h0,          32'h0000_0000, 16'ha5a5};
      vecs[16] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,          32'h0000_0000, 16'ha5a5};
      vecs[17] = '{1'b1, 4'hf, MB + 32'h4,    32'h0000_00ff, 32'h0000_0000, 16'ha5a5};
      vecs[18] = '{1'b1, 4'h0, MB + 32'h4,    32'h0,          32'h0000_0000, 16'ha5a5};

      reset = 1'b1; switch = 8'h00;
      bus.en = 1'b0; bus.we = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_rdata", bus.rdata, 32'h0);
      check("reset_led", {16'h0, led}, 32'h0);
      check("reset_irq", {31'h0, timer_irq}, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 19; i++) begin
         access(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         check($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
         check($sformatf("vec%0d_irq", i), {31'h0, timer_irq}, 32'h0);
      end

      // Switch synchronizer: visible to a read issued at the 3rd edge after the change
      switch = 8'h3c;
      access(1'b1, 4'h0, MB + 32'h4, 32'h0);
      check("sw_edge1", bus.rdata, 32'h0);
      access(1'b1, 4'h0, MB + 32'h4, 32'h0);
      check("sw_edge2", bus.rdata, 32'h0);
      access(1'b1, 4'h0, MB + 32'h4, 32'h0);
      check("sw_edge3", bus.rdata, 32'h0000_003c);

      // Timer 5, compare 8: flag sets at the 8->9 edge
      access(1'b1, 4'hf, MB + 32'h8, 32'd5);
      access(1'b1, 4'hf, MB + 32'hc, 32'd8);
      access(1'b1, 4'h0, MB + 32'h8, 32'h0);
      check("timer_rd6", bus.rdata, 32'd6);
      check("irq_t7", {31'h0, timer_irq}, 32'h0);
      idle();
      check("irq_t8", {31'h0, timer_irq}, 32'h0);
      idle();
      check("irq_t9", {31'h0, timer_irq}, 32'h1);
      access(1'b1, 4'h0, MB + 32'h8, 32'h0);
      check("timer_rd9", bus.rdata, 32'd9);
      check("irq_sticky", {31'h0, timer_irq}, 32'h1);
      access(1'b1, 4'h0, MB + 32'h10, 32'h0);
      check("status_rd", bus.rdata, 32'h1);
      access(1'b1, 4'h1, MB + 32'h10, 32'h1);
      check("w1c_clean", {31'h0, timer_irq}, 32'h0);
      access(1'b1, 4'hf, MB + 32'hc, 32'd13);
      access(1'b1, 4'h1, MB + 32'h10, 32'h1);
      check("w1c_vs_match", {31'h0, timer_irq}, 32'h1);
      access(1'b1, 4'h1, MB + 32'h10, 32'h1);
      check("w1c_clean2", {31'h0, timer_irq}, 32'h0);

      // Wrap from fffffffe
      access(1'b1, 4'hf, MB + 32'h8, 32'hffff_fffe);
      access(1'b1, 4'h0, MB + 32'h8, 32'h0);
      check("wrap_rd0", bus.rdata, 32'hffff_fffe);
      access(1'b1, 4'h0, MB + 32'h8, 32'h0);
      check("wrap_rd1", bus.rdata, 32'hffff_ffff);
      access(1'b1, 4'h0, MB + 32'h8, 32'h0);
      check("wrap_rd2", bus.rdata, 32'h0);

      // Arm irq, then reset during an LED write
      access(1'b1, 4'hf, MB + 32'hc, 32'd2);
      idle();
      check("irq_pre_reset", {31'h0, timer_irq}, 32'h1);
      access(1'b1, 4'h0, 32'h0000_0020, 32'h0);
      check("rd_pre_reset", bus.rdata, 32'hdead_beef);
      reset = 1'b1;
      access(1'b1, 4'hf, MB, 32'h0000_00ff);
      reset = 1'b0;
      check("rst_led", {16'h0, led}, 32'h0);
      check("rst_rdata", bus.rdata, 32'h0);
      check("rst_irq", {31'h0, timer_irq}, 32'h0);
      access(1'b1, 4'h0, MB + 32'h8, 32'h0);
      check("rst_timer0", bus.rdata, 32'h0);
      access(1'b1, 4'h0, MB + 32'h8, 32'h0);
      check("rst_timer1", bus.rdata, 32'h1);
      access(1'b1, 4'h0, MB + 32'hc, 32'h0);
      check("rst_cmp", bus.rdata, 32'hffff_ffff);
      access(1'b1, 4'h0, 32'h0000_0020, 32'h0);
      check("ram_kept", bus.rdata, 32'hdead_beef);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder (slave) end of the CPU's SRAM-style data port (en / we[3:0] / addr / wdata / rdata).
- Serves word-addressed on-chip RAM with byte-lane writes and a one-cycle registered read.
- Also serves a small MMIO window: LED register, synchronized switch input, free-running timer with compare and sticky match flag driving timer_irq.
- Sits between the CPU top and board I/O; it is the memory/confreg side the CPU data port talks to.

Parameters:
- ADDR_W, 12, RAM word-address width; depth = 2^ADDR_W 32-bit words.
- MMIO_BASE, 32'hbfaf_0000, MMIO window base; window size is 64 KB.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- en  input  1  request valid this cycle
- we  input  4  byte-lane write enables; 4'h0 with en=1 is a read
- addr  input  32  byte address; addr[1:0] ignored
- wdata  input  32  write data, lane i = wdata[8i+7:8i]
- rdata  output  32  read data, registered
- switch  input  8  asynchronous board switches
- led  output  16  LED register
- timer_irq  output  1  timer match status (STATUS bit0)

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high.
- Values after reset:
  - rdata = 0
  - led = 0
  - TIMER = 0
  - TIMER_CMP = 32'hffff_ffff
  - STATUS = 0 and timer_irq = 0
  - switch synchronizer flops = 0
  - RAM contents are not reset.
- Decode: MMIO when addr[31:16] == MMIO_BASE[31:16]; otherwise RAM, word index addr[ADDR_W+1:2]. Upper RAM address bits alias.
- Read: en=1, we=0 at edge N → rdata valid after edge N, i.e. during cycle N+1. rdata holds its value in every cycle without a read, including write cycles.
- Write: en=1, we≠0 → at the edge, each lane with we[i]=1 updates. Unselected lanes are unchanged. Applies to RAM and to writable MMIO registers.
- Read-after-write, same word: a read in the cycle after a write returns the new data.
- MMIO map (offset = addr[15:0]):
  - 0x0000 LED: RW, bits [15:0]; upper bits read 0 and ignore writes.
  - 0x0004 SWITCH: RO, {24'b0, sw_sync}. sw_sync comes through a 2-flop synchronizer, so a pin change is readable from the 3rd edge onward. Writes ignored.
  - 0x0008 TIMER: RW. Increments by 1 every cycle, wrapping 32'hffff_ffff → 0. On a write cycle, the result is the lane-merge of the old value and wdata, with no increment that cycle.
  - 0x000C TIMER_CMP: RW.
  - 0x0010 STATUS: bit0 = match, bits [31:1] read 0. Writing 1 to bit0 (we[0]=1) clears it.
  - Any other offset: reads 0, writes ignored.
- Match: if the pre-edge TIMER == TIMER_CMP, STATUS[0] sets at that edge and is sticky. If set and W1C clear occur in the same cycle, set wins. timer_irq = STATUS[0], registered.
- en=0: no state change except the timer increment and the switch synchronizer.
- reset asserted mid-access: the access is dropped; no RAM or register update at that edge; all outputs go to their reset values.
- Single port: one access per cycle; no back-pressure and no wait states.

Test Plan:
- Reset then word write/read:
  - Stimulus: write addr 0x0000_0010 = 32'h1234_5678 with we=4'hf, then read 0x10.
  - Required response: rdata = 32'h1234_5678 in the cycle after the read request; before that, rdata = 0.
- Byte lanes:
  - Stimulus: with word 0x10 = 32'h1234_5678, write we=4'b0101, wdata=32'haabb_ccdd, then read.
  - Required response: 32'h12bb_56dd. A read in the write cycle itself must leave rdata unchanged.
- Back-to-back write then read, same address:
  - Stimulus: write 0x20 = 32'hdead_beef, then read 0x20 in the next cycle.
  - Required response: 32'hdead_beef. Also check that addr 0x22 aliases word 0x20.
- MMIO LED/SWITCH:
  - Stimulus: write 0xbfaf_0000 = 32'hffff_a5a5; drive switch = 8'h3c.
  - Required response: led = 16'ha5a5 and readback = 32'h0000_a5a5. SWITCH read returns 32'h3c only from the 3rd edge after the pin change.
  - Also: an unmapped offset 0x0040 reads 0.
- Timer/compare/irq:
  - Stimulus: write TIMER = 5 and CMP = 8.
  - Required response: timer_irq rises at the edge where TIMER goes 8→9 and stays high; reading TIMER returns the expected count.
  - Stimulus: W1C of STATUS issued in the same cycle as a match (CMP = current value).
  - Required response: irq remains 1.
  - Stimulus: clean W1C with no match.
  - Required response: irq = 0.
  - Stimulus: TIMER = 32'hffff_fffe.
  - Required response: wraps to 0 after 2 cycles.
- Reset mid-operation:
  - Stimulus: assert reset in the same cycle as a write to LED = 16'h00ff.
  - Required response: led = 0, rdata = 0, TIMER = 0, timer_irq = 0 after the edge; previously written RAM word still reads back intact.
